// File: rtl/serial_logicunit_if.sv
// serial_logicunit_if: operand/result bundle between an operand source and
// serial_logicunit.
//   master : drives start, A, B, control; observes busy, done, out (, zero)
//   slave  : the engine side (serial_logicunit)
// Optional signal `zero` exists only when SERIAL_LOGICUNIT_ZERO_EN is defined.
interface serial_logicunit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       control;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
`ifdef SERIAL_LOGICUNIT_ZERO_EN
   logic             zero;
`endif

`ifdef SERIAL_LOGICUNIT_ZERO_EN
   modport master (output start, A, B, control, input busy, done, out, zero);
   modport slave  (input start, A, B, control, output busy, done, out, zero);
`else
   modport master (output start, A, B, control, input busy, done, out);
   modport slave  (input start, A, B, control, output busy, done, out);
`endif
endinterface

// File: rtl/serial_logicunit.sv
// serial_logicunit: bit-serial WIDTH-bit logic engine driving a single 1-bit
// logicunit. Operands are latched on an accepted start, fed LSB-first one bit
// per clock, and the result bits are shifted into `out` from the top. A
// one-cycle `done` pulse marks completion; a start in that cycle is accepted
// back-to-back.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : serial_logicunit_if.slave (start, A, B, control -> busy, done, out)
// Optional feature macro: SERIAL_LOGICUNIT_ZERO_EN adds registered `zero`
// (out == 0 at completion, 0 while an operation runs, 1 after reset).

// 1-bit logic cell: 0=AND, 1=OR, 2=NOR, 3=XOR.
module logicunit (
   input  logic       a,
   input  logic       b,
   input  logic [1:0] control,
   output logic       result
);
   always_comb begin
      result = 1'b0;
      case (control)
         2'd0:    result = a & b;
         2'd1:    result = a | b;
         2'd2:    result = ~(a | b);
         default: result = a ^ b;
      endcase
   end
endmodule

module serial_logicunit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   serial_logicunit_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [1:0]         op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               zero_q, zero_d;
   logic               lu_out_c;

   // Single shared bit cell, fed from the low end of the operand shifters.
   logicunit u_lu (
      .a       (a_sh_q[0]),
      .b       (b_sh_q[0]),
      .control (op_q),
      .result  (lu_out_c)
   );

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         op_q    <= 2'd0;
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      zero_d  = zero_q;

      case (state_q)
         RUN: begin
            out_d  = {lu_out_c, out_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + CNT_W'(1);
            // Counter holds the index of the bit being shifted this edge.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               zero_d  = (out_d == '0);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Start is honoured in IDLE and, for back-to-back use, in DONE.
      if (bus.start && (state_q != RUN)) begin
         state_d = RUN;
         a_sh_d  = bus.A;
         b_sh_d  = bus.B;
         op_d    = bus.control;
         cnt_d   = '0;
         out_d   = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         zero_d  = 1'b0;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.out  = out_q;

`ifdef SERIAL_LOGICUNIT_ZERO_EN
   assign bus.zero = zero_q;
`else
   // Zero flag tracking is kept internal only; it has no port in this build.
   logic unused_zero;
   assign unused_zero = zero_q;
`endif
endmodule

// File: tb/tb_serial_logicunit.sv
module tb_serial_logicunit;
   localparam int unsigned W = 32;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   serial_logicunit_if #(.WIDTH(W)) bus ();

   serial_logicunit #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] exp;
      bit          b2b;
   } vec_t;

   // Word-level reference of the four operations.
   function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string name, input logic exp);
`ifdef SERIAL_LOGICUNIT_ZERO_EN
      check(name, 32'(bus.zero), 32'(exp));
`else
      if (exp === 1'bx) $display("unreachable %s", name);
`endif
   endtask

   // One operation. Returns at the falling edge inside the done cycle.
   // b2b: caller is already in the done cycle, so start is driven immediately.
   // inject_at: edge index (after E0) at which a stray start is pulsed, 0 = none.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp, input bit b2b, input bit scramble,
                        input int inject_at, input string name);
      int edges;
      if (!b2b) @(negedge clock);
      bus.A = a; bus.B = b; bus.control = op; bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      check({name, "_busy_start"}, 32'(bus.busy), 32'd1);
      check({name, "_out_cleared"}, bus.out, 32'd0);
      check_zero({name, "_zero_cleared"}, 1'b0);
      edges = 0;
      while (bus.done !== 1'b1 && edges < 40) begin
         check({name, "_busy_run"}, 32'(bus.busy), 32'd1);
         if (scramble) begin
            bus.A = $urandom; bus.B = $urandom; bus.control = 2'($urandom_range(0, 3));
         end
         if (inject_at != 0 && edges == inject_at - 1) begin
            bus.A = ~a; bus.B = 32'h0000_1234; bus.control = 2'd2; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      bus.start = 1'b0;
      check({name, "_latency"}, 32'(edges), 32'd32);
      check({name, "_out"}, bus.out, exp);
      check({name, "_busy_done"}, 32'(bus.busy), 32'd0);
      check_zero({name, "_zero"}, (exp == 32'd0));
   endtask

   // Cycle after done with no new start: idle, result held.
   task automatic idle_check(input logic [31:0] exp, input string name);
      @(negedge clock);
      check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
      check({name, "_out_hold"}, bus.out, exp);
   endtask

   initial begin
      vec_t tbl[5];
      bit   saw_done;
      bit   nb2b;
      logic [31:0] ra, rb;
      logic [1:0]  rop;

      tbl[0] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 2'd0, 32'hF000_F000, 1'b0};
      tbl[1] = '{32'h1234_5678, 32'h0F0F_0F0F, 2'd1, 32'h1F3F_5F7F, 1'b0};
      tbl[2] = '{32'h0000_0000, 32'h0000_0000, 2'd2, 32'hFFFF_FFFF, 1'b1};
      tbl[3] = '{32'hAAAA_AAAA, 32'hFFFF_FFFF, 2'd3, 32'h5555_5555, 1'b0};
      tbl[4] = '{32'h5A5A_5A5A, 32'h5A5A_5A5A, 2'd3, 32'h0000_0000, 1'b1};

      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.control = 2'd0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_out", bus.out, 32'd0);
      check_zero("rst_zero", 1'b1);
      reset = 1'b0;

      // Directed vectors, including back-to-back starts in the done cycle.
      for (int i = 0; i < 5; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp, tbl[i].b2b, 1'b0, 0,
               $sformatf("tbl%0d", i));
         if (i == 4 || !tbl[i + 1].b2b) idle_check(tbl[i].exp, $sformatf("tbl%0d", i));
      end

      // Start during RUN is ignored and not queued.
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 10, "busy_start");
      idle_check(32'hFFFF_FFFF, "busy_start");
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
      end
      check("busy_start_no_queue", 32'(saw_done), 32'd0);

      // Reset in the middle of an OR operation.
      @(negedge clock);
      bus.A = 32'h1357_9BDF; bus.B = 32'h0F0F_0000; bus.control = 2'd1; bus.start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (14) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_out", bus.out, 32'd0);
      check_zero("midrst_zero", 1'b1);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("midrst_no_done", 32'(saw_done), 32'd0);
      do_op(32'h1357_9BDF, 32'h0F0F_0000, 2'd1, 32'h1F5F_9BDF, 1'b0, 1'b0, 0, "after_rst");
      idle_check(32'h1F5F_9BDF, "after_rst");

      // Inputs wiggling every cycle during RUN.
      do_op(32'hC3C3_1234, 32'h0FF0_8421, 2'd3, ref_op(32'hC3C3_1234, 32'h0FF0_8421, 2'd3),
            1'b0, 1'b1, 0, "stable");
      idle_check(ref_op(32'hC3C3_1234, 32'h0FF0_8421, 2'd3), "stable");

      // Randomized operations against the word-level model.
      nb2b = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
         if (i % 5 == 4) rb = ra;
         do_op(ra, rb, rop, ref_op(ra, rb, rop), nb2b, 1'($urandom_range(0, 1)), 0,
               $sformatf("rnd%0d", i));
         nb2b = 1'($urandom_range(0, 1));
         if (!nb2b || i == 19) idle_check(ref_op(ra, rb, rop), $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
